regfile_mp: RTL

- Parametrised multi-port integer register file with a per-register pending-write scoreboard.
- Serves as the next-generation architectural register store for the dual-issue / multi-cycle pipeline.
- Provides NRD asynchronous read ports and NWR synchronous write ports.
- Tracks busy (in-flight producer) status per register so that issue logic can detect RAW hazards.
- Register 0 is optionally hardwired to zero.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_mp.sv | 91 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Low bit of field idx in a flat bus of width-sized fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle between issue/writeback logic (master) and the register file (slave).
interface regfile_if import regfile_pkg::*; #(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = addr_w(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                claim_en;
    logic [AW-1:0]       claim_addr;
    logic [NREGS-1:0]    busy_vec;
    logic                sb_err;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, claim_en, claim_addr,
        input  rd_data, rd_busy, busy_vec, sb_err
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, claim_en, claim_addr,
        output rd_data, rd_busy, busy_vec, sb_err
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, claim/clear resolution and
// the sticky sb_err flag.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NREGS    = DEF_NREGS,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR-1:0]    wr_clr_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              claim_en_i,
    input  logic [AW-1:0]     claim_addr_i,
    output logic [NREGS-1:0]  busy_vec_o,
    output logic              sb_err_o
);

    logic [NREGS-1:0] busy_q, busy_d, set_vec, clr_vec;
    logic             sb_err_q, sb_err_d;

    always_comb begin : resolve
        logic [AW-1:0] ak;
        ak       = '0;
        set_vec  = '0;
        clr_vec  = '0;
        sb_err_d = sb_err_q;
        if (claim_en_i && !(ZERO_REG != 0 && claim_addr_i == '0))
            set_vec[claim_addr_i] = 1'b1;
        for (int k = 0; k < NWR; k++) begin
            ak = wr_addr_i[slice_lo(k, AW) +: AW];
            // Retiring a producer that was never claimed means issue logic lost track.
            if (wr_en_i[k] && wr_clr_i[k]) begin
                clr_vec[ak] = 1'b1;
                if (!busy_q[ak] && !set_vec[ak] && !(ZERO_REG != 0 && ak == '0))
                    sb_err_d = 1'b1;
            end
            for (int j = 0; j < k; j++) begin
                if (wr_en_i[k] && wr_en_i[j] && ak != '0 &&
                    wr_addr_i[slice_lo(j, AW) +: AW] == ak)
                    sb_err_d = 1'b1;
            end
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
        if (ZERO_REG != 0)
            busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign sb_err_o   = sb_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/clears onto the read ports.
module regfile_mp import regfile_pkg::*; #(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic    clk,
    input  logic    reset_n,
    regfile_if.slave rf
);

    localparam int AW = addr_w(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_vec;

    // Ports applied in ascending order so the highest-indexed port wins a collision.
    always_comb begin : write_merge
        logic [AW-1:0] wa;
        wa     = '0;
        regs_d = regs_q;
        for (int k = 0; k < NWR; k++) begin
            wa = rf.wr_addr[slice_lo(k, AW) +: AW];
            if (rf.wr_en[k] && !(ZERO_REG != 0 && wa == '0))
                regs_d[wa] = rf.wr_data[slice_lo(k, XLEN) +: XLEN];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en_i      (rf.wr_en),
        .wr_clr_i     (rf.wr_clr),
        .wr_addr_i    (rf.wr_addr),
        .claim_en_i   (rf.claim_en),
        .claim_addr_i (rf.claim_addr),
        .busy_vec_o   (busy_vec),
        .sb_err_o     (rf.sb_err)
    );

    assign rf.busy_vec = busy_vec;

    always_comb begin : read_mux
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rb;
        ra         = '0;
        rdat       = '0;
        rb         = 1'b0;
        rf.rd_data = '0;
        rf.rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            ra   = rf.rd_addr[slice_lo(p, AW) +: AW];
            rdat = regs_q[ra];
            rb   = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (rf.wr_en[k] && ra != '0 && rf.wr_addr[slice_lo(k, AW) +: AW] == ra) begin
                    rdat = rf.wr_data[slice_lo(k, XLEN) +: XLEN];
                    if (rf.wr_clr[k] && !(rf.claim_en && rf.claim_addr == ra))
                        rb = 1'b0;
                end
            end
`endif
            if (ZERO_REG != 0 && ra == '0) begin
                rdat = '0;
                rb   = 1'b0;
            end
            rf.rd_data[slice_lo(p, XLEN) +: XLEN] = rdat;
            rf.rd_busy[p] = rb;
        end
    end

endmodule
